// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: FSM state encodings, field constants
// and the timer width helper.
package song_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_PLAY  = 3'd2,
      ST_GAP   = 3'd3,
      ST_END   = 3'd4
   } state_t;

   // A zero duration terminates a song; a zero note is a rest.
   localparam int END_MARKER_DUR = 0;
   localparam int REST_NOTE      = 0;

   // Smallest width able to hold max_val.
   function automatic int cnt_width(input longint unsigned max_val);
      int w;
      w = 1;
      while ((longint'(1) << w) <= max_val) w++;
      return w;
   endfunction

endpackage

// File: rtl/song_sequencer_dur_timer.sv
// Loadable down-counter shared by the PLAY and GAP phases; hold freezes the count
// and zero flags an expired interval.
module song_sequencer_dur_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             hold,
   input  logic [CNT_W-1:0] load_val,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (!hold && cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/song_sequencer.sv
// Song playback FSM: fetches {note, dur} entries from the song ROM and drives the tone
// generator. Define SONG_LOOP_EN to repeat the song until stop instead of returning to idle.
module song_sequencer
   import song_sequencer_pkg::*;
#(
   parameter int          SONG_W          = 4,
   parameter int          IDX_W           = 6,
   parameter int          NOTE_W          = 4,
   parameter int          DUR_W           = 4,
   parameter int unsigned DUR_UNIT_CYCLES = 5_000_000,
   parameter int unsigned GAP_CYCLES      = 1_000_000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    pause,
   input  logic [SONG_W-1:0]       selected_song,
   output logic                    rom_req,
   output logic [SONG_W+IDX_W-1:0] rom_addr,
   input  logic                    rom_ack,
   input  logic [NOTE_W+DUR_W-1:0] rom_data,
   output logic [NOTE_W-1:0]       note_out,
   output logic                    busy,
   output logic                    done,
   output logic [IDX_W-1:0]        cur_index
);

   localparam longint unsigned PLAY_MAX = ((longint'(1) << DUR_W) - 1) * DUR_UNIT_CYCLES;
   localparam longint unsigned CNT_MAX  = (PLAY_MAX > GAP_CYCLES) ? PLAY_MAX : GAP_CYCLES;
   localparam int              CNT_W    = cnt_width(CNT_MAX);
   localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : CNT_W'(GAP_CYCLES - 1);

   state_t              state;
   logic [SONG_W-1:0]   song_q;
   logic [IDX_W-1:0]    index_q;
   logic [NOTE_W-1:0]   note_q;

   logic [NOTE_W-1:0]   rom_note;
   logic [DUR_W-1:0]    rom_dur;
   logic [CNT_W-1:0]    play_len;
   logic                tmr_load;
   logic                tmr_hold;
   logic [CNT_W-1:0]    tmr_val;
   logic                tmr_zero;
   logic                tmr_expired;

   assign rom_note    = rom_data[NOTE_W+DUR_W-1 -: NOTE_W];
   assign rom_dur     = rom_data[DUR_W-1:0];
   assign play_len    = CNT_W'(rom_dur) * CNT_W'(DUR_UNIT_CYCLES);
   assign tmr_expired = tmr_zero && !pause;

   // Timers are loaded with length-1 so that an interval of N cycles ends on count 0.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      if (!stop) begin
         if (state == ST_FETCH && rom_ack && rom_dur != DUR_W'(END_MARKER_DUR)) begin
            tmr_load = 1'b1;
            tmr_val  = play_len - CNT_W'(1);
         end else if (state == ST_PLAY && tmr_expired && GAP_CYCLES != 0) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
         end
      end
   end

   assign tmr_hold = pause || !(state == ST_PLAY || state == ST_GAP);

   song_sequencer_dur_timer #(.CNT_W(CNT_W)) u_dur_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .hold     (tmr_hold),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         song_q  <= '0;
         index_q <= '0;
         note_q  <= '0;
         rom_req <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else if (stop) begin
         state   <= ST_IDLE;
         note_q  <= '0;
         rom_req <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  song_q  <= selected_song;
                  index_q <= '0;
                  rom_req <= 1'b1;
                  busy    <= 1'b1;
                  state   <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (rom_ack) begin
                  rom_req <= 1'b0;
                  if (rom_dur == DUR_W'(END_MARKER_DUR)) begin
                     done  <= 1'b1;
                     state <= ST_END;
                  end else begin
                     note_q <= rom_note;
                     state  <= ST_PLAY;
                  end
               end
            end
            ST_PLAY: begin
               if (tmr_expired) begin
                  note_q <= NOTE_W'(REST_NOTE);
                  if (GAP_CYCLES != 0) begin
                     state <= ST_GAP;
                  end else if (index_q == '1) begin
                     done  <= 1'b1;
                     state <= ST_END;
                  end else begin
                     index_q <= index_q + IDX_W'(1);
                     rom_req <= 1'b1;
                     state   <= ST_FETCH;
                  end
               end
            end
            ST_GAP: begin
               // The last addressable entry ends the song rather than wrapping the index.
               if (tmr_expired) begin
                  if (index_q == '1) begin
                     done  <= 1'b1;
                     state <= ST_END;
                  end else begin
                     index_q <= index_q + IDX_W'(1);
                     rom_req <= 1'b1;
                     state   <= ST_FETCH;
                  end
               end
            end
            ST_END: begin
`ifdef SONG_LOOP_EN
               index_q <= '0;
               rom_req <= 1'b1;
               state   <= ST_FETCH;
`else
               busy  <= 1'b0;
               state <= ST_IDLE;
`endif
            end
            default: begin
               state   <= ST_IDLE;
               rom_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   // Pause mutes immediately; the held note resumes when pause drops.
   assign note_out  = pause ? NOTE_W'(REST_NOTE) : note_q;
   assign rom_addr  = {song_q, index_q};
   assign cur_index = index_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with a short duration unit and gap; a behavioural
// ROM answers requests after a programmable delay.
module tb_song_sequencer;

   logic       clk = 1'b0;
   logic       reset, start, stop, pause;
   logic [3:0] selected_song;
   logic       rom_req;
   logic [9:0] rom_addr;
   logic       rom_ack = 1'b0;
   logic [7:0] rom_data = 8'h00;
   logic [3:0] note_out;
   logic       busy, done;
   logic [5:0] cur_index;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] rom [0:1023];
   bit  auto_en   = 1'b1;
   bit  man_ack   = 1'b0;
   bit  ack_given = 1'b0;
   int  ack_delay = 0;
   int  wait_cnt  = 0;

   song_sequencer #(
      .DUR_UNIT_CYCLES (4),
      .GAP_CYCLES      (3)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .stop          (stop),
      .pause         (pause),
      .selected_song (selected_song),
      .rom_req       (rom_req),
      .rom_addr      (rom_addr),
      .rom_ack       (rom_ack),
      .rom_data      (rom_data),
      .note_out      (note_out),
      .busy          (busy),
      .done          (done),
      .cur_index     (cur_index)
   );

   always #5 clk = ~clk;

   // ROM responder: one ack per request, ack_delay cycles after rom_req is seen.
   always @(negedge clk) begin
      if (!auto_en) begin
         rom_ack  = man_ack;
         rom_data = 8'h32;
      end else begin
         rom_ack = 1'b0;
         if (!rom_req) begin
            ack_given = 1'b0;
            wait_cnt  = 0;
         end else if (!ack_given) begin
            if (wait_cnt >= ack_delay) begin
               rom_ack   = 1'b1;
               rom_data  = rom[rom_addr];
               ack_given = 1'b1;
            end else begin
               wait_cnt++;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [3:0] song);
      selected_song = song;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic cleanup();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      tick();
   endtask

   typedef struct {
      int         t;
      logic [3:0] note;
      logic       req;
      logic       bsy;
      logic       dn;
      logic [5:0] idx;
      logic [9:0] addr;
   } vec_t;

   vec_t vt [12];

   initial begin
      int  vi;
      int  n3;
      int  viol;
      int  fetch_t;
      bit  seen;
      bit  ok;

      for (int a = 0; a < 1024; a++) rom[a] = 8'h00;
      rom[64] = 8'h32;
      rom[65] = 8'h51;
      rom[66] = 8'h00;
      for (int a = 128; a < 192; a++) rom[a] = 8'h11;

      // Song 1 timeline with immediate ack, unit = 4 cycles, gap = 3 cycles.
      vt[0]  = '{0,  4'd0, 1'b1, 1'b1, 1'b0, 6'd0, 10'd64};
      vt[1]  = '{1,  4'd3, 1'b0, 1'b1, 1'b0, 6'd0, 10'd64};
      vt[2]  = '{8,  4'd3, 1'b0, 1'b1, 1'b0, 6'd0, 10'd64};
      vt[3]  = '{9,  4'd0, 1'b0, 1'b1, 1'b0, 6'd0, 10'd64};
      vt[4]  = '{11, 4'd0, 1'b0, 1'b1, 1'b0, 6'd0, 10'd64};
      vt[5]  = '{12, 4'd0, 1'b1, 1'b1, 1'b0, 6'd1, 10'd65};
      vt[6]  = '{13, 4'd5, 1'b0, 1'b1, 1'b0, 6'd1, 10'd65};
      vt[7]  = '{16, 4'd5, 1'b0, 1'b1, 1'b0, 6'd1, 10'd65};
      vt[8]  = '{17, 4'd0, 1'b0, 1'b1, 1'b0, 6'd1, 10'd65};
      vt[9]  = '{20, 4'd0, 1'b1, 1'b1, 1'b0, 6'd2, 10'd66};
      vt[10] = '{21, 4'd0, 1'b0, 1'b1, 1'b1, 6'd2, 10'd66};
      vt[11] = '{22, 4'd0, 1'b0, 1'b0, 1'b0, 6'd2, 10'd66};

      reset = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      pause = 1'b0;
      selected_song = 4'd0;
      tick();
      tick();
      check("reset_note", note_out, 0);
      check("reset_req",  rom_req,  0);
      check("reset_busy", busy,     0);
      check("reset_done", done,     0);
      check("reset_idx",  cur_index, 0);
      check("reset_addr", rom_addr, 0);
      reset = 1'b0;
      tick();

      // Basic playback of song 1.
      pulse_start(4'd1);
      selected_song = 4'd7;
      vi = 0;
      for (int c = 0; c <= 22; c++) begin
         if (c > 0) tick();
         if (vi < 12 && vt[vi].t == c) begin
            check($sformatf("t%0d_note", c), note_out,  vt[vi].note);
            check($sformatf("t%0d_req",  c), rom_req,   vt[vi].req);
            check($sformatf("t%0d_busy", c), busy,      vt[vi].bsy);
            check($sformatf("t%0d_done", c), done,      vt[vi].dn);
            check($sformatf("t%0d_idx",  c), cur_index, vt[vi].idx);
            check($sformatf("t%0d_addr", c), rom_addr,  vt[vi].addr);
            vi++;
         end
      end
      tick();

      // Slow ROM: request and address held until ack, note one cycle after ack.
      ack_delay = 5;
      pulse_start(4'd1);
      ok = 1'b1;
      for (int c = 0; c <= 5; c++) begin
         if (c > 0) tick();
         if (rom_req !== 1'b1 || rom_addr !== 10'd64) ok = 1'b0;
      end
      check("slow_req_held", ok, 1);
      check("slow_note_before", note_out, 0);
      tick();
      check("slow_note_after", note_out, 3);
      check("slow_req_dropped", rom_req, 0);
      cleanup();
      ack_delay = 0;

      // Pause for 100 cycles during the first note.
      pulse_start(4'd1);
      n3 = 0;
      viol = 0;
      fetch_t = -1;
      for (int c = 1; c <= 130; c++) begin
         tick();
         if (note_out == 4'd3) n3++;
         if (pause && note_out != 4'd0) viol++;
         if (fetch_t < 0 && rom_req) fetch_t = c;
         if (c == 3) pause = 1'b1;
         if (c == 103) pause = 1'b0;
      end
      check("pause_mute", viol, 0);
      check("pause_note_cycles", n3, 8);
      check("pause_play_len", fetch_t, 112);
      cleanup();

      // Stop during an open fetch; a late ack must be ignored.
      auto_en = 1'b0;
      pulse_start(4'd1);
      tick();
      check("stopf_req_open", rom_req, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stopf_busy", busy, 0);
      check("stopf_req", rom_req, 0);
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (done || busy || note_out != 4'd0) seen = 1'b1;
         tick();
      end
      check("stopf_late_ack_ignored", seen, 0);
      auto_en = 1'b1;
      tick();

      // start and stop together from idle: stop wins.
      selected_song = 4'd1;
      start = 1'b1;
      stop  = 1'b1;
      tick();
      start = 1'b0;
      stop  = 1'b0;
      check("startstop_busy", busy, 0);
      check("startstop_req", rom_req, 0);

      // start while busy is ignored.
      pulse_start(4'd1);
      tick();
      tick();
      tick();
      pulse_start(4'd2);
      check("rebusy_note", note_out, 3);
      check("rebusy_idx", cur_index, 0);
      check("rebusy_addr", rom_addr, 64);
      cleanup();

      // Asynchronous reset in the middle of a note.
      pulse_start(4'd1);
      tick();
      tick();
      #2 reset = 1'b1;
      #1;
      check("areset_note", note_out, 0);
      check("areset_busy", busy, 0);
      check("areset_idx", cur_index, 0);
      tick();
      reset = 1'b0;
      tick();

      // 64 entries with no end marker.
      pulse_start(4'd2);
      ok = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      check("full_done_seen", ok, 1);
      check("full_last_idx", cur_index, 63);
      check("full_busy_at_done", busy, 1);
      tick();
`ifdef SONG_LOOP_EN
      check("loop_busy", busy, 1);
      check("loop_req", rom_req, 1);
      check("loop_addr", rom_addr, 128);
`else
      check("end_busy", busy, 0);
      check("end_req", rom_req, 0);
      check("end_done_pulse", done, 0);
`endif
      cleanup();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no end of test, expected end before 1000000 ns");
      $fatal(1);
   end

endmodule
